xadac_vrf_sched: RTL and testbench
==================================

XADAC_VRF_SCHED -- requirements
Module: xadac_vrf_sched

Interface
REQ-001 Parameter NoReq, default 3, number of VRF write requesters (range 1..8).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 rsv_valid  input  1  dispatch requests reservation of a destination vector register.
REQ-005 rsv_addr  input  VecAddrT  register to reserve.
REQ-006 rsv_ready  output  1  reservation accepted this cycle.
REQ-007 chk_addr  input  NoVs x VecAddrT  source registers queried for hazards.
REQ-008 chk_busy  output  NoVs  per-source pending-write flag.
REQ-009 wr_valid  input  NoReq  requester i offers a write-back.
REQ-010 wr_addr  input  NoReq x VecAddrT  write-back destination per requester.
REQ-011 wr_data  input  NoReq x VecDataT  write-back data per requester.
REQ-012 wr_ready  output  NoReq  write-back i accepted this cycle.
REQ-013 vrf_we / vrf_waddr / vrf_wdata  output  1 / VecAddrT / VecDataT  single VRF write port.
REQ-014 busy  output  NoVec  scoreboard state, one bit per vector register.
REQ-015 err  output  1  sticky protocol-error flag.

Function
REQ-016 Scoreboard holds one busy bit per register; busy output equals the register contents.
REQ-017 rsv_ready SHALL equal !busy[rsv_addr]; no dependence on rsv_valid (WAW stall).
REQ-018 Reservation handshake (rsv_valid & rsv_ready) SHALL set busy[rsv_addr] at the next edge.
REQ-019 chk_busy[i] SHALL equal busy[chk_addr[i]], combinational, no bypass of same-cycle reservation or clear.
REQ-020 Arbiter grants at most one requester per cycle; wr_ready[i] high only for the granted i, only when wr_valid[i] high.
REQ-021 Arbitration round-robin: search starts at index after the last granted requester, wrapping NoReq-1 -> 0; pointer advances only on a grant.
REQ-022 Write handshake SHALL register the granted addr/data into the output stage; vrf_we high exactly one cycle later (latency 1), low otherwise.
REQ-023 vrf_waddr/vrf_wdata SHALL hold last written values when vrf_we low.
REQ-024 At the edge ending a vrf_we cycle, busy[vrf_waddr] SHALL clear, so chk_busy drops in the first cycle the VRF holds the new data.
REQ-025 Reservation and clear of the same register in one cycle cannot occur (rsv_ready low while busy); clear of register A and reservation of register B in one cycle SHALL both take effect.
REQ-026 Write handshake whose wr_addr is not busy SHALL set err at the next edge; the write still proceeds; err stays high until reset.
REQ-027 Two requesters targeting the same register in one cycle: one granted per REQ-021, the other waits; second write sets err if busy already cleared.
REQ-028 Arbiter accepts a new write every cycle; output stage never back-pressures.

Reset
REQ-029 rst high SHALL clear all busy bits, err, vrf_we, and set the round-robin pointer so requester 0 has highest priority.
REQ-030 vrf_waddr/vrf_wdata SHALL reset to 0.
REQ-031 Reset mid-operation SHALL drop the in-flight output-stage write (vrf_we low the cycle after rst); during rst, wr_ready and rsv_ready SHALL be 0.

Structure
REQ-032 NoReq default, VecAddrT, VecDataT, NoVec, NoVs, SizeT SHALL come from xadac_pkg; no new local typedefs for shared types.
REQ-033 Round-robin arbiter SHALL be a sub-module xadac_rr_arb (req/grant vectors, pointer internal), reusable elsewhere.
REQ-034 Scoreboard, output stage, error logic reside in xadac_vrf_sched; it instantiates xadac_vrf_phy externally-connected, not internally.

Verification
REQ-035 Reserve v3, query chk_addr=v3 -> chk_busy 0 same cycle, 1 next cycle; rsv_addr=v3 again -> rsv_ready 0.
REQ-036 All three requesters valid continuously, distinct reserved addrs -> grants 0,1,2,0,... one per cycle; vrf_we continuous from cycle after first grant.
REQ-037 Requester 1 writes v5 (reserved) with data 0xA5.. -> vrf_we=1, vrf_waddr=5 one cycle later; busy[5]=0 the cycle after.
REQ-038 Write to unreserved v7 -> write occurs, err=1 next cycle, remains 1 until rst.
REQ-039 Same cycle: clear v2 via write, reserve v4 -> both busy[2]=0 and busy[4]=1 after the edge.
REQ-040 Assert rst with write in output stage and busy[1,6] set -> vrf_we 0, busy all 0, next grant goes to requester 0.

Source files
------------

// File: rtl/xadac_pkg.sv
// rtl/xadac_pkg.sv - shared vector-register types and sizes for the xadac cluster
package xadac_pkg;

    localparam int NoVec    = 32;
    localparam int NoVs     = 3;
    localparam int NoReq    = 3;
    localparam int VecAddrW = $clog2(NoVec);
    localparam int VecDataW = 64;

    typedef logic [VecAddrW-1:0]          VecAddrT;
    typedef logic [VecDataW-1:0]          VecDataT;
    typedef logic [$clog2(NoVec+1)-1:0]   SizeT;

endpackage

// File: rtl/xadac_vrf_sched_if.sv
// rtl/xadac_vrf_sched_if.sv - reservation, hazard-query, write-back and VRF write-port bundle
interface xadac_vrf_sched_if #(
    parameter int NoReq = xadac_pkg::NoReq
);
    import xadac_pkg::*;

    logic                      rsv_valid;
    VecAddrT                   rsv_addr;
    logic                      rsv_ready;
    VecAddrT [NoVs-1:0]        chk_addr;
    logic    [NoVs-1:0]        chk_busy;
    logic    [NoReq-1:0]       wr_valid;
    VecAddrT [NoReq-1:0]       wr_addr;
    VecDataT [NoReq-1:0]       wr_data;
    logic    [NoReq-1:0]       wr_ready;
    logic                      vrf_we;
    VecAddrT                   vrf_waddr;
    VecDataT                   vrf_wdata;
    logic    [NoVec-1:0]       busy;
    logic                      err;

    modport master (
        output rsv_valid, rsv_addr, chk_addr, wr_valid, wr_addr, wr_data,
        input  rsv_ready, chk_busy, wr_ready, vrf_we, vrf_waddr, vrf_wdata, busy, err
    );

    modport slave (
        input  rsv_valid, rsv_addr, chk_addr, wr_valid, wr_addr, wr_data,
        output rsv_ready, chk_busy, wr_ready, vrf_we, vrf_waddr, vrf_wdata, busy, err
    );

endinterface

// File: rtl/xadac_rr_arb.sv
// rtl/xadac_rr_arb.sv - round-robin arbiter, search starts after the last granted requester
module xadac_rr_arb #(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    output logic [N-1:0] grant
);
    localparam int PtrW = (N > 1) ? $clog2(N) : 1;

    logic [PtrW-1:0] last_q;
    logic [PtrW-1:0] gidx;
    logic [PtrW-1:0] sidx;
    logic [N-1:0]    req_m;
    int              idx;

    // No grants while reset is held, so nothing is accepted and then dropped.
    assign req_m = req & {N{!rst}};

    always_comb begin
        grant = '0;
        gidx  = last_q;
        idx   = 0;
        sidx  = '0;
        for (int k = 0; k < N; k++) begin
            idx = int'(last_q) + 1 + k;
            if (idx >= N) idx = idx - N;
            sidx = PtrW'(idx);
            if (grant == '0 && req_m[sidx]) begin
                grant[sidx] = 1'b1;
                gidx        = sidx;
            end
        end
    end

    // Pointer starts at N-1 so requester 0 wins first after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= PtrW'(N - 1);
        end else if (|grant) begin
            last_q <= gidx;
        end
    end

endmodule

// File: rtl/xadac_vrf_sched.sv
// rtl/xadac_vrf_sched.sv - VRF write scoreboard, write-back arbitration and registered VRF write stage
module xadac_vrf_sched #(
    parameter int NoReq = xadac_pkg::NoReq
) (
    input  logic                    clk,
    input  logic                    rst,
    xadac_vrf_sched_if.slave        bus
);
    import xadac_pkg::*;

    logic [NoVec-1:0] busy_q;
    logic [NoVec-1:0] busy_next;
    logic             err_q;
    logic             we_q;
    VecAddrT          waddr_q;
    VecDataT          wdata_q;
    logic [NoReq-1:0] grant;
    VecAddrT          sel_addr;
    VecDataT          sel_data;
    logic             wr_hs;
    logic             rsv_hs;

    xadac_rr_arb #(.N(NoReq)) u_arb (
        .clk   (clk),
        .rst   (rst),
        .req   (bus.wr_valid),
        .grant (grant)
    );

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NoReq; i++) begin
            if (grant[i]) begin
                sel_addr = bus.wr_addr[i];
                sel_data = bus.wr_data[i];
            end
        end
    end

    assign wr_hs         = |grant;
    assign bus.wr_ready  = grant;
    assign bus.rsv_ready = !rst && !busy_q[bus.rsv_addr];
    assign rsv_hs        = bus.rsv_valid && bus.rsv_ready;

    // Hazard lookups see only registered state; same-cycle set/clear is not bypassed.
    always_comb begin
        bus.chk_busy = '0;
        for (int i = 0; i < NoVs; i++) begin
            bus.chk_busy[i] = busy_q[bus.chk_addr[i]];
        end
    end

    // Clear fires as the VRF write lands; a reservation of the same register cannot coincide.
    always_comb begin
        busy_next = busy_q;
        if (we_q)   busy_next[waddr_q]      = 1'b0;
        if (rsv_hs) busy_next[bus.rsv_addr] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q  <= '0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            busy_q <= busy_next;
            we_q   <= wr_hs;
            if (wr_hs) begin
                waddr_q <= sel_addr;
                wdata_q <= sel_data;
                if (!busy_q[sel_addr]) err_q <= 1'b1;
            end
        end
    end

    assign bus.busy      = busy_q;
    assign bus.err       = err_q;
    assign bus.vrf_we    = we_q;
    assign bus.vrf_waddr = waddr_q;
    assign bus.vrf_wdata = wdata_q;

endmodule

// File: tb/tb_xadac_vrf_sched.sv
// tb/tb_xadac_vrf_sched.sv - randomized and directed bench for xadac_vrf_sched against a scoreboard model
module tb_xadac_vrf_sched;
    import xadac_pkg::*;

    localparam int NR = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    xadac_vrf_sched_if #(.NoReq(NR)) bus ();

    xadac_vrf_sched #(.NoReq(NR)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference state: which registers await a write, the pending VRF write, and who was served last.
    logic [NoVec-1:0] m_busy = '0;
    logic             m_err = 1'b0;
    logic             m_we = 1'b0;
    VecAddrT          m_waddr = '0;
    VecDataT          m_wdata = '0;
    int               m_last = NR - 1;
    int               exp_g;
    logic             exp_rr;

    task automatic expect_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic begin_cycle();
        @(negedge clk);
        rst           = 1'b0;
        bus.rsv_valid = 1'b0;
        bus.wr_valid  = '0;
    endtask

    task automatic eval_cycle();
        logic [NoVs-1:0] exp_chk;
        logic [NR-1:0]   exp_wr;
        #1;
        exp_rr = !rst && !m_busy[bus.rsv_addr];
        exp_g  = -1;
        if (!rst) begin
            for (int k = 1; k <= NR; k++) begin
                int i;
                i = (m_last + k) % NR;
                if (exp_g < 0 && bus.wr_valid[i]) exp_g = i;
            end
        end
        exp_wr = '0;
        if (exp_g >= 0) exp_wr[exp_g] = 1'b1;
        for (int i = 0; i < NoVs; i++) exp_chk[i] = m_busy[bus.chk_addr[i]];
        expect_eq("rsv_ready", 64'(bus.rsv_ready), 64'(exp_rr));
        expect_eq("wr_ready",  64'(bus.wr_ready),  64'(exp_wr));
        expect_eq("chk_busy",  64'(bus.chk_busy),  64'(exp_chk));
        expect_eq("busy",      64'(bus.busy),      64'(m_busy));
        expect_eq("err",       64'(bus.err),       64'(m_err));
        expect_eq("vrf_we",    64'(bus.vrf_we),    64'(m_we));
        expect_eq("vrf_waddr", 64'(bus.vrf_waddr), 64'(m_waddr));
        expect_eq("vrf_wdata", 64'(bus.vrf_wdata), 64'(m_wdata));
    endtask

    task automatic end_cycle();
        logic [NoVec-1:0] nb;
        if (rst) begin
            m_busy  = '0;
            m_err   = 1'b0;
            m_we    = 1'b0;
            m_waddr = '0;
            m_wdata = '0;
            m_last  = NR - 1;
        end else begin
            nb = m_busy;
            if (m_we) nb[m_waddr] = 1'b0;
            if (bus.rsv_valid && exp_rr) nb[bus.rsv_addr] = 1'b1;
            if (exp_g >= 0) begin
                if (!m_busy[bus.wr_addr[exp_g]]) m_err = 1'b1;
                m_we    = 1'b1;
                m_waddr = bus.wr_addr[exp_g];
                m_wdata = bus.wr_data[exp_g];
                m_last  = exp_g;
            end else begin
                m_we = 1'b0;
            end
            m_busy = nb;
        end
        @(posedge clk);
    endtask

    task automatic idle_cycle();
        begin_cycle();
        eval_cycle();
        end_cycle();
    endtask

    task automatic reserve(input int a);
        begin_cycle();
        bus.rsv_valid = 1'b1;
        bus.rsv_addr  = VecAddrT'(a);
        eval_cycle();
        end_cycle();
    endtask

    task automatic reset_cycle();
        begin_cycle();
        rst = 1'b1;
        eval_cycle();
        end_cycle();
    endtask

    initial begin
        bus.rsv_valid = 1'b0;
        bus.rsv_addr  = '0;
        bus.chk_addr  = '0;
        bus.wr_valid  = '0;
        bus.wr_addr   = '0;
        bus.wr_data   = '0;
        repeat (2) @(posedge clk);

        // Reset state
        begin_cycle();
        eval_cycle();
        expect_eq("rst_busy", 64'(bus.busy), 64'd0);
        expect_eq("rst_vrf_we", 64'(bus.vrf_we), 64'd0);
        end_cycle();

        // Reserve v3: not visible to the query until the edge, then blocks a re-reserve
        begin_cycle();
        bus.rsv_valid   = 1'b1;
        bus.rsv_addr    = 5'd3;
        bus.chk_addr[0] = 5'd3;
        eval_cycle();
        expect_eq("v3_chk_same", 64'(bus.chk_busy[0]), 64'd0);
        end_cycle();
        begin_cycle();
        bus.rsv_valid = 1'b1;
        bus.rsv_addr  = 5'd3;
        eval_cycle();
        expect_eq("v3_chk_next", 64'(bus.chk_busy[0]), 64'd1);
        expect_eq("v3_waw", 64'(bus.rsv_ready), 64'd0);
        end_cycle();

        // Requester 1 writes reserved v5
        reserve(5);
        begin_cycle();
        bus.wr_valid   = 3'b010;
        bus.wr_addr[1] = 5'd5;
        bus.wr_data[1] = 64'hA5A5_A5A5_A5A5_A5A5;
        eval_cycle();
        end_cycle();
        begin_cycle();
        eval_cycle();
        expect_eq("v5_we", 64'(bus.vrf_we), 64'd1);
        expect_eq("v5_addr", 64'(bus.vrf_waddr), 64'd5);
        end_cycle();
        begin_cycle();
        eval_cycle();
        expect_eq("v5_clear", 64'(bus.busy[5]), 64'd0);
        expect_eq("v5_hold", 64'(bus.vrf_wdata), 64'hA5A5_A5A5_A5A5_A5A5);
        end_cycle();

        // Clear v2 and reserve v4 on the same edge
        reserve(2);
        begin_cycle();
        bus.wr_valid   = 3'b001;
        bus.wr_addr[0] = 5'd2;
        bus.wr_data[0] = 64'h1234;
        eval_cycle();
        end_cycle();
        reserve(4);
        begin_cycle();
        eval_cycle();
        expect_eq("v2_clear", 64'(bus.busy[2]), 64'd0);
        expect_eq("v4_set", 64'(bus.busy[4]), 64'd1);
        end_cycle();

        // Three requesters valid continuously to distinct reserved registers
        reserve(10);
        reserve(11);
        reserve(12);
        for (int c = 0; c < 6; c++) begin
            begin_cycle();
            bus.wr_valid = 3'b111;
            for (int i = 0; i < NR; i++) begin
                bus.wr_addr[i] = VecAddrT'(10 + i);
                bus.wr_data[i] = 64'(c * 16 + i);
            end
            eval_cycle();
            end_cycle();
        end
        idle_cycle();

        // Unreserved write to v7 raises sticky err
        reset_cycle();
        begin_cycle();
        bus.wr_valid   = 3'b100;
        bus.wr_addr[2] = 5'd7;
        eval_cycle();
        end_cycle();
        begin_cycle();
        eval_cycle();
        expect_eq("v7_err", 64'(bus.err), 64'd1);
        end_cycle();
        idle_cycle();

        // Reset with a write in flight and v1/v6 busy
        reset_cycle();
        reserve(1);
        reserve(6);
        begin_cycle();
        bus.wr_valid   = 3'b100;
        bus.wr_addr[2] = 5'd1;
        eval_cycle();
        end_cycle();
        begin_cycle();
        rst          = 1'b1;
        bus.wr_valid = 3'b111;
        eval_cycle();
        expect_eq("rst_wr_ready", 64'(bus.wr_ready), 64'd0);
        end_cycle();
        begin_cycle();
        bus.wr_valid = 3'b111;
        eval_cycle();
        expect_eq("rst_we_drop", 64'(bus.vrf_we), 64'd0);
        expect_eq("rst_busy_clr", 64'(bus.busy), 64'd0);
        expect_eq("rst_grant0", 64'(bus.wr_ready), 64'd1);
        end_cycle();

        // Randomized traffic over a small register window to provoke hazards
        for (int c = 0; c < 400; c++) begin
            int busy_q[$];
            begin_cycle();
            rst = ($urandom_range(0, 99) < 2);
            bus.rsv_valid = $urandom_range(0, 1);
            bus.rsv_addr  = VecAddrT'($urandom_range(0, 7));
            for (int i = 0; i < NoVs; i++) bus.chk_addr[i] = VecAddrT'($urandom_range(0, 7));
            for (int r = 0; r < NoVec; r++) if (m_busy[r]) busy_q.push_back(r);
            bus.wr_valid = NR'($urandom);
            for (int i = 0; i < NR; i++) begin
                if (busy_q.size() > 0 && $urandom_range(0, 9) < 8)
                    bus.wr_addr[i] = VecAddrT'(busy_q[$urandom_range(0, busy_q.size() - 1)]);
                else
                    bus.wr_addr[i] = VecAddrT'($urandom_range(0, 7));
                bus.wr_data[i] = {$urandom, $urandom};
            end
            eval_cycle();
            end_cycle();
        end
        idle_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
